// File: rtl/dmx8_pkg.sv
// Shared definitions for the 1-to-8 demux deserializer: state encoding and datapath widths.
package dmx8_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/dmx8.sv
// Combinational 1-to-8 demux built as a three-level 1-to-2 tree (s2, then s1, then s0).
module dmx8
    import dmx8_pkg::*;
(
    output logic [BYTE_W-1:0] y,
    input  logic              d,
    input  logic              en,
    input  logic              s2,
    input  logic              s1,
    input  logic              s0
);

    logic       root_s;
    logic [1:0] lvl2_s;
    logic [3:0] lvl1_s;

    assign root_s = d & en;

    assign lvl2_s[1] = root_s &  s2;
    assign lvl2_s[0] = root_s & ~s2;

    assign lvl1_s[3] = lvl2_s[1] &  s1;
    assign lvl1_s[2] = lvl2_s[1] & ~s1;
    assign lvl1_s[1] = lvl2_s[0] &  s1;
    assign lvl1_s[0] = lvl2_s[0] & ~s1;

    assign y[7] = lvl1_s[3] &  s0;
    assign y[6] = lvl1_s[3] & ~s0;
    assign y[5] = lvl1_s[2] &  s0;
    assign y[4] = lvl1_s[2] & ~s0;
    assign y[3] = lvl1_s[1] &  s0;
    assign y[2] = lvl1_s[1] & ~s0;
    assign y[1] = lvl1_s[0] &  s0;
    assign y[0] = lvl1_s[0] & ~s0;

endmodule

// File: rtl/dmx8_sipo.sv
// Serial-in, byte-out deserializer: a bit-index counter steers each accepted bit into a shadow
// register through a 1-to-8 demux; completed bytes are published on q with a one-cycle strobe.
module dmx8_sipo
    import dmx8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              d_in,
    input  logic              d_valid,
    output logic [BYTE_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  bit_cnt
);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [BYTE_W-1:0]   shadow_r;
    logic [CNT_W-1:0]    idx_s;
    logic                shift_en_s;
    logic [BYTE_W-1:0]   load_s;
    logic [BYTE_W-1:0]   merged_s;

    assign idx_s      = MSB_FIRST ? (3'd7 - cnt_r) : cnt_r;
    assign shift_en_s = (state_r == SHIFT) & d_valid;

    // The demux carries a constant 1 so its outputs act as one-hot per-bit load enables.
    dmx8 u_dmx8 (
        .y  (load_s),
        .d  (1'b1),
        .en (shift_en_s),
        .s2 (idx_s[2]),
        .s1 (idx_s[1]),
        .s0 (idx_s[0])
    );

    assign merged_s = (shadow_r & ~load_s) | ({BYTE_W{d_in}} & load_s);
    assign busy     = (state_r == SHIFT);
    assign bit_cnt  = cnt_r;

    // FSM, bit counter, shadow register and output register; clear overrides all activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= 3'd0;
            shadow_r <= 8'h00;
            q        <= 8'h00;
            q_valid  <= 1'b0;
        end else if (clear) begin
            state_r  <= IDLE;
            cnt_r    <= 3'd0;
            shadow_r <= 8'h00;
            q_valid  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    q_valid <= 1'b0;
                    if (start) begin
                        state_r  <= SHIFT;
                        cnt_r    <= 3'd0;
                        shadow_r <= 8'h00;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SHIFT: begin
                    q_valid <= 1'b0;
                    if (d_valid) begin
                        shadow_r <= merged_s;
                        cnt_r    <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            q       <= merged_s;
                            q_valid <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    q_valid <= 1'b0;
                    if (start) begin
                        state_r  <= SHIFT;
                        cnt_r    <= 3'd0;
                        shadow_r <= 8'h00;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 3'd0;
                    shadow_r <= 8'h00;
                    q_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
